// File: rtl/classifier_seq_ctrl.sv
// classifier_seq_ctrl
// Sequences one inference through the fc layer and then the relu/normalize
// stage, and returns a single classification per start request through a
// valid/ready handshake. Both waits are supervised by a timeout. A wrapping
// counter records how many results the consumer has accepted.
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-low reset
//   start, busy          inference request in / sequencer active out
//   fc_en, fc_done,      fc layer enable, completion strobe and scores
//   fc_scores
//   relu_clear, relu_en, relu stage clear pulse, enable and the latched
//   relu_fc_results      copy of the fc scores
//   relu_done,           relu stage completion strobe and one-hot class
//   relu_class_hotcoded
//   result_valid/ready   result handshake
//   result_class/index/  captured one-hot class, encoded index, error flag
//   result_error
//   image_count          accepted results, wraps
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start
// FC_RUN   | fc layer enabled, waiting for fc_done or timeout
// RELU_CLR | one-cycle clear pulse to the relu stage
// RELU_RUN | relu stage enabled, waiting for relu_done or timeout
// OUTPUT   | result_valid held until result_ready

module classifier_seq_ctrl #(
  parameter int CLASSIFICATIONS = 10,
  parameter int ELEMENT_SIZE    = 30,
  parameter int IDX_W           = 4,
  parameter int TIMEOUT_CYCLES  = 1023,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  output logic                                    busy,
  output logic                                    fc_en,
  input  logic                                    fc_done,
  input  logic [CLASSIFICATIONS*ELEMENT_SIZE-1:0] fc_scores,
  output logic                                    relu_clear,
  output logic                                    relu_en,
  output logic [CLASSIFICATIONS*ELEMENT_SIZE-1:0] relu_fc_results,
  input  logic                                    relu_done,
  input  logic [CLASSIFICATIONS-1:0]              relu_class_hotcoded,
  output logic                                    result_valid,
  input  logic                                    result_ready,
  output logic [CLASSIFICATIONS-1:0]              result_class,
  output logic [IDX_W-1:0]                        result_index,
  output logic                                    result_error,
  output logic [CNT_WIDTH-1:0]                    image_count
);

  localparam int SW    = CLASSIFICATIONS * ELEMENT_SIZE;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FC_RUN   = 3'd1,
    RELU_CLR = 3'd2,
    RELU_RUN = 3'd3,
    OUTPUT   = 3'd4
  } state_t;

  state_t                     state, state_nxt;
  logic [TMO_W-1:0]           tmo_cnt, tmo_nxt;
  logic                       busy_nxt, fc_en_nxt, relu_clear_nxt, relu_en_nxt;
  logic [SW-1:0]              fc_results_nxt;
  logic                       valid_nxt, error_nxt;
  logic [CLASSIFICATIONS-1:0] class_nxt;
  logic [IDX_W-1:0]           index_nxt;
  logic [CNT_WIDTH-1:0]       count_nxt;
  logic                       tmo_hit;

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [CLASSIFICATIONS-1:0] v);
    lowest_idx = '0;
    for (int i = CLASSIFICATIONS - 1; i >= 0; i--)
      if (v[i]) lowest_idx = IDX_W'(i);
  endfunction

  function automatic logic is_onehot(input logic [CLASSIFICATIONS-1:0] v);
    is_onehot = (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  // The counter starts at 0 on entry, so hitting TIMEOUT_CYCLES-1 without a
  // done strobe means the wait has lasted exactly TIMEOUT_CYCLES cycles.
  assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      tmo_cnt         <= '0;
      busy            <= 1'b0;
      fc_en           <= 1'b0;
      relu_clear      <= 1'b0;
      relu_en         <= 1'b0;
      relu_fc_results <= '0;
      result_valid    <= 1'b0;
      result_class    <= '0;
      result_index    <= '0;
      result_error    <= 1'b0;
      image_count     <= '0;
    end else begin
      state           <= state_nxt;
      tmo_cnt         <= tmo_nxt;
      busy            <= busy_nxt;
      fc_en           <= fc_en_nxt;
      relu_clear      <= relu_clear_nxt;
      relu_en         <= relu_en_nxt;
      relu_fc_results <= fc_results_nxt;
      result_valid    <= valid_nxt;
      result_class    <= class_nxt;
      result_index    <= index_nxt;
      result_error    <= error_nxt;
      image_count     <= count_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    tmo_nxt        = tmo_cnt;
    fc_en_nxt      = fc_en;
    relu_clear_nxt = 1'b0;
    relu_en_nxt    = relu_en;
    fc_results_nxt = relu_fc_results;
    valid_nxt      = result_valid;
    class_nxt      = result_class;
    index_nxt      = result_index;
    error_nxt      = result_error;
    count_nxt      = image_count;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = FC_RUN;
          fc_en_nxt = 1'b1;
          tmo_nxt   = '0;
        end
      end
      FC_RUN: begin
        // fc_done takes priority over a timeout landing in the same cycle
        if (fc_done) begin
          state_nxt      = RELU_CLR;
          fc_en_nxt      = 1'b0;
          relu_clear_nxt = 1'b1;
          fc_results_nxt = fc_scores;
        end else if (tmo_hit) begin
          state_nxt = OUTPUT;
          fc_en_nxt = 1'b0;
          valid_nxt = 1'b1;
          class_nxt = '0;
          index_nxt = '0;
          error_nxt = 1'b1;
        end else begin
          tmo_nxt = tmo_cnt + 1'b1;
        end
      end
      RELU_CLR: begin
        state_nxt   = RELU_RUN;
        relu_en_nxt = 1'b1;
        tmo_nxt     = '0;
      end
      RELU_RUN: begin
        if (relu_done) begin
          state_nxt   = OUTPUT;
          relu_en_nxt = 1'b0;
          valid_nxt   = 1'b1;
          class_nxt   = relu_class_hotcoded;
          index_nxt   = lowest_idx(relu_class_hotcoded);
          error_nxt   = !is_onehot(relu_class_hotcoded);
        end else if (tmo_hit) begin
          state_nxt   = OUTPUT;
          relu_en_nxt = 1'b0;
          valid_nxt   = 1'b1;
          class_nxt   = '0;
          index_nxt   = '0;
          error_nxt   = 1'b1;
        end else begin
          tmo_nxt = tmo_cnt + 1'b1;
        end
      end
      OUTPUT: begin
        if (result_ready) begin
          valid_nxt = 1'b0;
          count_nxt = image_count + 1'b1;
          if (start) begin
            state_nxt = FC_RUN;
            fc_en_nxt = 1'b1;
            tmo_nxt   = '0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt   = IDLE;
        fc_en_nxt   = 1'b0;
        relu_en_nxt = 1'b0;
        valid_nxt   = 1'b0;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

endmodule
